// File: rtl/bram_fifo_ctl.sv
`default_nettype none
// ============================================================================
// Module      : bram_fifo_ctl
// Description : Valid/ready FIFO controller driving one external 1-cycle-read
//               bram, with a 2-entry first-word-fall-through output stage.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_fifo_ctl #(
    parameter int DATA_SZ = 16,
    parameter int ADDR_SZ = 8,
    parameter int DEPTH   = (1 << ADDR_SZ)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [DATA_SZ-1:0] i_data,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [DATA_SZ-1:0] o_data,
    output logic [ADDR_SZ+1:0] o_count,
    output logic               o_wr_en,
    output logic [ADDR_SZ-1:0] o_waddr,
    output logic [DATA_SZ-1:0] o_wdata,
    output logic               o_rd_en,
    output logic [ADDR_SZ-1:0] o_raddr,
    input  logic [DATA_SZ-1:0] i_rdata
);

    localparam logic [1:0]       c_EMPTY    = 2'd0;
    localparam logic [1:0]       c_ONE      = 2'd1;
    localparam logic [1:0]       c_TWO      = 2'd2;
    localparam logic [ADDR_SZ:0] c_FULL_CNT = (ADDR_SZ + 1)'(DEPTH);

    logic [ADDR_SZ:0]   r_wr_ptr;
    logic [ADDR_SZ:0]   r_rd_ptr;
    logic               r_rd_pend;
    logic [1:0]         r_state;
    logic [DATA_SZ-1:0] r_data;
    logic [DATA_SZ-1:0] r_skid;

    logic [ADDR_SZ:0]   w_bram_cnt;
    logic               w_bram_full;
    logic               w_push;
    logic               w_pop;
    logic               w_issue;
    logic [1:0]         w_occ;
    logic [2:0]         w_stage_load;

    assign w_bram_cnt  = r_wr_ptr - r_rd_ptr;
    assign w_bram_full = (w_bram_cnt == c_FULL_CNT);

    // Built from registered state and reset only, so it never waits on i_ready.
    assign o_ready = !w_bram_full && !i_rst;
    assign o_valid = (r_state != c_EMPTY);
    assign o_data  = r_data;

    assign w_push = i_valid && o_ready;
    assign w_pop  = o_valid && i_ready;

    // State encoding doubles as the output-stage occupancy.
    assign w_occ        = r_state;
    assign w_stage_load = {1'b0, w_occ} + {2'b00, r_rd_pend} - {2'b00, w_pop};
    assign w_issue      = (w_bram_cnt != '0) && (w_stage_load < 3'd2) && !i_rst;

    assign o_wr_en = w_push;
    assign o_waddr = r_wr_ptr[ADDR_SZ-1:0];
    assign o_wdata = i_data;
    assign o_rd_en = w_issue;
    assign o_raddr = r_rd_ptr[ADDR_SZ-1:0];

    assign o_count = {1'b0, w_bram_cnt}
                   + {{(ADDR_SZ + 1){1'b0}}, r_rd_pend}
                   + {{ADDR_SZ{1'b0}}, w_occ};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_rd_pend <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_rd_pend <= w_issue;
        end
    end

    // Output stage: r_rd_pend marks bram data landing on i_rdata this cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= c_EMPTY;
            r_data  <= '0;
            r_skid  <= '0;
        end else begin
            case (r_state)
                c_EMPTY: begin
                    if (r_rd_pend) begin
                        r_state <= c_ONE;
                        r_data  <= i_rdata;
                    end
                end
                c_ONE: begin
                    if (r_rd_pend && !w_pop) begin
                        r_state <= c_TWO;
                        r_skid  <= i_rdata;
                    end else if (r_rd_pend && w_pop) begin
                        r_data  <= i_rdata;
                    end else if (w_pop) begin
                        r_state <= c_EMPTY;
                    end
                end
                c_TWO: begin
                    if (w_pop) begin
                        r_state <= c_ONE;
                        r_data  <= r_skid;
                    end
                end
                default: r_state <= c_EMPTY;
            endcase
        end
    end

    a_no_land_in_two: assert property (@(posedge i_clk) disable iff (i_rst)
        !(r_state == c_TWO && r_rd_pend));
    a_bram_cnt_bound: assert property (@(posedge i_clk) disable iff (i_rst)
        (w_bram_cnt <= c_FULL_CNT));

endmodule
`default_nettype wire

// File: tb/tb_bram_fifo_ctl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bram_fifo_ctl
// Description : Self-checking bench for bram_fifo_ctl with a behavioural bram.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_fifo_ctl;

    localparam int DATA_SZ = 16;
    localparam int ADDR_SZ = 8;
    localparam int DEPTH   = 256;

    logic               i_clk = 1'b0;
    logic               i_rst;
    logic               i_valid;
    logic               o_ready;
    logic [DATA_SZ-1:0] i_data;
    logic               o_valid;
    logic               i_ready;
    logic [DATA_SZ-1:0] o_data;
    logic [ADDR_SZ+1:0] o_count;
    logic               o_wr_en;
    logic [ADDR_SZ-1:0] o_waddr;
    logic [DATA_SZ-1:0] o_wdata;
    logic               o_rd_en;
    logic [ADDR_SZ-1:0] o_raddr;
    logic [DATA_SZ-1:0] r_rdata;

    logic [DATA_SZ-1:0] mem [0:DEPTH-1];

    int errors = 0;
    int checks = 0;
    logic [DATA_SZ-1:0] sb [$];

    always #5 i_clk = ~i_clk;

    bram_fifo_ctl #(
        .DATA_SZ (DATA_SZ),
        .ADDR_SZ (ADDR_SZ),
        .DEPTH   (DEPTH)
    ) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_count (o_count),
        .o_wr_en (o_wr_en),
        .o_waddr (o_waddr),
        .o_wdata (o_wdata),
        .o_rd_en (o_rd_en),
        .o_raddr (o_raddr),
        .i_rdata (r_rdata)
    );

    // Registered-read bram; contents deliberately survive reset.
    always_ff @(posedge i_clk) begin
        if (o_wr_en) mem[o_waddr] <= o_wdata;
        if (o_rd_en) r_rdata <= mem[o_raddr];
    end

    typedef struct packed {
        logic        v;
        logic        r;
        logic [15:0] d;
        logic        ev;
        logic [15:0] ed;
        logic [9:0]  ec;
        logic        er;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, score the handshakes the coming edge will take.
    task automatic drive(input logic v, input logic r, input logic [15:0] d);
        i_valid = v;
        i_ready = r;
        i_data  = d;
        if (v && o_ready) sb.push_back(d);
        if (o_valid && r) begin
            if (sb.size() == 0) chk("pop_unexpected", {16'h0, o_data}, 32'hFFFF_FFFF);
            else                chk("pop_data", {16'h0, o_data}, {16'h0, sb.pop_front()});
        end
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        int sent, pops, first_pop, last_pop, cyc, acc;
        logic [15:0] held;

        i_rst   = 1'b1;
        i_valid = 1'b1;
        i_ready = 1'b0;
        i_data  = 16'h5555;
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_valid", {31'h0, o_valid}, 0);
        chk("rst_count", {22'h0, o_count}, 0);
        chk("rst_ready", {31'h0, o_ready}, 0);
        chk("rst_wr_en", {31'h0, o_wr_en}, 0);
        chk("rst_rd_en", {31'h0, o_rd_en}, 0);
        i_valid = 1'b0;
        i_rst   = 1'b0;
        #1;
        chk("post_rst_ready", {31'h0, o_ready}, 1);

        // Single word latency, then two words landing into the skid slot.
        tbl[0] = '{1'b1, 1'b1, 16'h0001, 1'b0, 16'h0000, 10'd1, 1'b1};
        tbl[1] = '{1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 10'd1, 1'b1};
        tbl[2] = '{1'b0, 1'b1, 16'h0000, 1'b1, 16'h0001, 10'd1, 1'b1};
        tbl[3] = '{1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 10'd0, 1'b1};
        tbl[4] = '{1'b1, 1'b0, 16'h00A1, 1'b0, 16'h0000, 10'd1, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 16'h00A2, 1'b0, 16'h0000, 10'd2, 1'b1};
        tbl[6] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h00A1, 10'd2, 1'b1};
        tbl[7] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h00A1, 10'd2, 1'b1};
        tbl[8] = '{1'b0, 1'b1, 16'h0000, 1'b1, 16'h00A2, 10'd1, 1'b1};
        tbl[9] = '{1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 10'd0, 1'b1};
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].v, tbl[i].r, tbl[i].d);
            chk($sformatf("tbl%0d_valid", i), {31'h0, o_valid}, {31'h0, tbl[i].ev});
            chk($sformatf("tbl%0d_count", i), {22'h0, o_count}, {22'h0, tbl[i].ec});
            chk($sformatf("tbl%0d_ready", i), {31'h0, o_ready}, {31'h0, tbl[i].er});
            if (tbl[i].ev)
                chk($sformatf("tbl%0d_data", i), {16'h0, o_data}, {16'h0, tbl[i].ed});
        end

        // Continuous stream: first word at the third sample, then no bubbles.
        sent = 0; pops = 0; first_pop = -1; last_pop = -1; cyc = 0;
        while (pops < 1024 && cyc < 1200) begin
            if (o_valid) begin
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
                pops++;
            end
            if (sent < 1024 && o_ready) begin
                drive(1'b1, 1'b1, sent[15:0]);
                sent++;
            end else begin
                drive(1'b0, 1'b1, 16'h0);
            end
            cyc++;
        end
        chk("stream_pops", pops, 1024);
        chk("stream_first", first_pop, 3);
        chk("stream_no_bubble", last_pop - first_pop, 1023);
        chk("stream_empty", {22'h0, o_count}, 0);

        // Fill until refused: capacity is DEPTH+2.
        acc = 0; cyc = 0;
        while (o_ready && cyc < 400) begin
            drive(1'b1, 1'b0, 16'h1000 + acc[15:0]);
            acc++;
            cyc++;
        end
        drive(1'b0, 1'b0, 16'h0);
        drive(1'b0, 1'b0, 16'h0);
        chk("fill_accepted", acc, DEPTH + 2);
        chk("fill_count", {22'h0, o_count}, DEPTH + 2);
        chk("fill_head", {16'h0, o_data}, 32'h1000);
        held = o_data;
        repeat (3) drive(1'b1, 1'b0, 16'hDEAD);
        chk("fill_hold_data", {16'h0, o_data}, {16'h0, held});
        chk("fill_hold_ready", {31'h0, o_ready}, 0);
        chk("fill_hold_count", {22'h0, o_count}, DEPTH + 2);

        // Pop from full: that push refused, the next one accepted.
        chk("full_ready_before", {31'h0, o_ready}, 0);
        drive(1'b1, 1'b1, 16'h7777);
        chk("full_pop_count", {22'h0, o_count}, DEPTH + 1);
        chk("full_pop_ready", {31'h0, o_ready}, 1);
        drive(1'b1, 1'b0, 16'h7777);
        chk("full_repush_count", {22'h0, o_count}, DEPTH + 2);
        chk("full_repush_ready", {31'h0, o_ready}, 0);
        cyc = 0;
        while ((sb.size() != 0 || o_valid) && cyc < 600) begin
            drive(1'b0, 1'b1, 16'h0);
            cyc++;
        end
        chk("drain_sb", sb.size(), 0);
        chk("drain_count", {22'h0, o_count}, 0);

        // Reset with 10 words held and a read in flight.
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 16'h2000 + 16'(i));
        chk("pre_rst_count", {22'h0, o_count}, 10);
        drive(1'b1, 1'b1, 16'h200A);
        chk("inflight_count", {22'h0, o_count}, 10);
        #2 i_rst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'h0, o_valid}, 0);
        chk("mid_rst_count", {22'h0, o_count}, 0);
        chk("mid_rst_ready", {31'h0, o_ready}, 0);
        sb.delete();
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b0;
        #1;
        drive(1'b1, 1'b1, 16'hBEEF);
        repeat (8) drive(1'b0, 1'b1, 16'h0);
        chk("post_rst_sb", sb.size(), 0);
        chk("post_rst_count", {22'h0, o_count}, 0);

        // Random traffic against the scoreboard; pointers wrap many times.
        for (int i = 0; i < 10000; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));
            chk("rand_count", {22'h0, o_count}, sb.size());
        end
        cyc = 0;
        while ((sb.size() != 0 || o_valid) && cyc < 600) begin
            drive(1'b0, 1'b1, 16'h0);
            cyc++;
        end
        chk("rand_drain_sb", sb.size(), 0);
        chk("rand_drain_count", {22'h0, o_count}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
